// File: rtl/nand_pkg.sv
// Shared types and constants for the nand-style datapath blocks.
// State encodings, default widths and the carry helper live here.
package nand_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } sa_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/Xor.sv
// Two-input exclusive-or assembled from four nand gates.
// Shared primitive for the adder datapath.
module Xor (
  input  logic a,
  input  logic b,
  output logic out
);

  logic w_nab;
  logic w_na;
  logic w_nb;

  assign w_nab = ~(a & b);
  assign w_na  = ~(a & w_nab);
  assign w_nb  = ~(b & w_nab);
  assign out   = ~(w_na & w_nb);

endmodule

// File: rtl/full_adder_bit.sv
// One-bit full adder; sum from two Xor primitives.
// Carry uses the propagate term shared with the sum path.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic w_p;

  Xor u_xor_ab (
    .a   (a_i),
    .b   (b_i),
    .out (w_p)
  );

  Xor u_xor_pc (
    .a   (w_p),
    .b   (c_i),
    .out (s_o)
  );

  assign c_o = (a_i & b_i) | (c_i & w_p);

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial two's-complement adder, one bit per clock.
// start/busy/done handshake; results held until the next start.
module serial_adder16
  import nand_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  sa_state_t r_state;
  sa_state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic             w_load;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  full_adder_bit u_fa (
    .a_i (r_a[0]),
    .b_i (r_b[0]),
    .c_i (r_c),
    .s_o (w_s),
    .c_o (w_c)
  );

  assign w_run     = (r_state == S_RUN);
  assign w_last    = w_run && (r_cnt == LAST);
  assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
    end else if (w_load) begin
      r_a    <= a_i;
      r_b    <= b_i;
      r_res  <= '0;
      r_cnt  <= '0;
      r_c    <= cin_i;
    end else if (w_run) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_res  <= w_res_nxt;
      r_c    <= w_c;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // r_c on the last bit is the carry into the MSB.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_res_nxt;
      r_cout <= w_c;
      r_ovf  <= r_c ^ w_c;
    end
  end

  assign busy_o = w_run;
  assign done_o = (r_state == S_DONE);
  assign sum_o  = r_sum;
  assign cout_o = r_cout;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_serial_adder16.sv
// Directed and randomised checks for serial_adder16.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_serial_adder16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder16 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  task automatic do_add(
    input  logic [15:0] ia,
    input  logic [15:0] ib,
    input  logic        ic,
    output int          lat,
    output int          bcnt
  );
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    lat   = 0;
    bcnt  = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0",
               {busy, done, sum, cout, ovf});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      failures++;
      $display("FAIL reset_rel got=%h exp=0",
               {busy, done, sum, cout, ovf});
    end
  endtask

  task automatic test_basic();
    int lat;
    int bc;
    do_add(16'h0001, 16'h0001, 1'b0, lat, bc);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL basic_lat got=%0d exp=17", lat);
    end
    checks++;
    if (bc !== 16) begin
      failures++;
      $display("FAIL basic_busy got=%0d exp=16", bc);
    end
    checks++;
    if ({sum, cout, ovf} !== {16'h0002, 2'b00}) begin
      failures++;
      $display("FAIL basic_res got=%h/%b/%b exp=0002/0/0",
               sum, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, sum} !== {2'b00, 16'h0002}) begin
      failures++;
      $display("FAIL basic_idle got=%b%b/%h exp=00/0002",
               done, busy, sum);
    end
  endtask

  task automatic test_boundary();
    int lat;
    int bc;
    do_add(16'hFFFF, 16'h0001, 1'b0, lat, bc);
    checks++;
    if ({sum, cout, ovf} !== {16'h0000, 2'b10}) begin
      failures++;
      $display("FAIL allones got=%h/%b/%b exp=0000/1/0",
               sum, cout, ovf);
    end
    do_add(16'h7FFF, 16'h0001, 1'b0, lat, bc);
    checks++;
    if ({sum, cout, ovf} !== {16'h8000, 2'b01}) begin
      failures++;
      $display("FAIL maxpos got=%h/%b/%b exp=8000/0/1",
               sum, cout, ovf);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    int nd;
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h4321;
    cin   = 1'b1;
    n     = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (n == 1) start = 1'b0;
      if (n == 5) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b0;
      end
      if (n == 6) start = 1'b0;
      if (n == 8) begin
        checks++;
        if (sum !== 16'h8000) begin
          failures++;
          $display("FAIL run_hold got=%h exp=8000", sum);
        end
      end
    end
    checks++;
    if (n !== 17) begin
      failures++;
      $display("FAIL ign_lat got=%0d exp=17", n);
    end
    checks++;
    if ({sum, cout, ovf} !== {16'h5556, 2'b00}) begin
      failures++;
      $display("FAIL ign_res got=%h/%b/%b exp=5556/0/0",
               sum, cout, ovf);
    end
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL ign_extra got=%0d exp=0", nd);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int nd;
    int t1;
    int t2;
    logic [15:0] s1;
    logic [17:0] r2;
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b0;
    n  = 0;
    nd = 0;
    t1 = 0;
    t2 = 0;
    s1 = '0;
    r2 = '0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (t1 != 0 && n == t1 + 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_busy got=%b exp=1", busy);
        end
      end
      if (done) begin
        nd++;
        if (nd == 1) begin
          t1    = n;
          s1    = sum;
          start = 1'b1;
          a     = 16'h8000;
          b     = 16'h8000;
          cin   = 1'b0;
        end else begin
          t2 = n;
          r2 = {sum, cout, ovf};
        end
      end
    end
    checks++;
    if (nd !== 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=2", nd);
    end
    checks++;
    if (t1 !== 17 || t2 !== 34) begin
      failures++;
      $display("FAIL b2b_time got=%0d,%0d exp=17,34", t1, t2);
    end
    checks++;
    if (s1 !== 16'h3333) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=3333", s1);
    end
    checks++;
    if (r2 !== {16'h0000, 2'b11}) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=00003", r2);
    end
  endtask

  task automatic test_async_reset();
    int n;
    int nd;
    int lat;
    int bc;
    @(negedge clk);
    start = 1'b1;
    a     = 16'h5555;
    b     = 16'h1111;
    cin   = 1'b0;
    n     = 0;
    while (n < 7) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      failures++;
      $display("FAIL arst_out got=%h exp=0",
               {busy, done, sum, cout, ovf});
    end
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL arst_done got=%0d exp=0", nd);
    end
    do_add(16'h00FF, 16'h0001, 1'b0, lat, bc);
    checks++;
    if (lat !== 17 || sum !== 16'h0100) begin
      failures++;
      $display("FAIL arst_after got=%0d/%h exp=17/0100",
               lat, sum);
    end
  endtask

  task automatic test_random();
    int lat;
    int bc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] ref_v;
    logic        ref_o;
    for (int i = 0; i < 1000; i++) begin
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      rc    = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      ref_o = (ra[15] == rb[15]) && (ref_v[15] != ra[15]);
      do_add(ra, rb, rc, lat, bc);
      checks++;
      if (lat !== 17 ||
          {cout, sum, ovf} !== {ref_v, ref_o}) begin
        failures++;
        $display("FAIL rand_%0d a=%h b=%h c=%b got=%0d/%b%h/%b exp=17/%h/%b",
                 i, ra, rb, rc, lat, cout, sum, ovf,
                 ref_v, ref_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
